// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq.
//   start/bin   : request, driven by the master
//   busy/valid  : status, driven by the converter
//   err/bcd     : result of the last completed request
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 6,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  valid;
  logic                  err;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, valid, err, bcd);
  modport slave  (input start, bin, output busy, valid, err, bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble).
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bin_to_bcd_seq_if
//            start/bin in, busy/valid/err/bcd out (digit 0 in bcd[3:0])
// One value per request; BIN_W shift cycles per legal value. Values above
// MAX_VAL complete on the accepting edge with err=1 and all digits 4'hF.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 6,
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 59
) (
  input logic            clk,
  input logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);
  localparam int SW = DIGITS*4 + BIN_W;   // scratch: {digit field, binary field}
  localparam int CW = $clog2(BIN_W+1);

  if (10**DIGITS <= MAX_VAL) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for MAX_VAL");
  end
  if (longint'(MAX_VAL) > (longint'(1) << BIN_W) - 1) begin : g_bad_max
    $error("bin_to_bcd_seq: MAX_VAL not representable in BIN_W bits");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic [SW-1:0]       adj, shifted;
  logic [31:0]         bin_ext;

  // Zero-extended so the range test stays meaningful when MAX_VAL is the
  // largest BIN_W-bit value.
  assign bin_ext = 32'(bus.bin);

  // Add-3 correction on every digit nibble, then one left shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = scratch_q[BIN_W+4*i +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bin_ext > 32'(MAX_VAL)) begin
            bcd_d   = '1;
            err_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            scratch_d = {{(DIGITS*4){1'b0}}, bus.bin};
            cnt_d     = CW'(BIN_W);
            busy_d    = 1'b1;
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[SW-1 -: 4*DIGITS];
          err_d   = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.bcd   = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 6-bit/2-digit instance (ua) and a
// 10-bit/4-digit instance (ub) sharing clock and reset.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(6),  .DIGITS(2)) ia();
  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(4)) ib();

  bin_to_bcd_seq #(.BIN_W(6), .DIGITS(2), .MAX_VAL(59)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .MAX_VAL(1023)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_bcd(input int v, input int digits, input int maxv);
    logic [31:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    if (v > maxv) begin
      r = '0;
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  // n = edges after the accepting edge until valid seen; nb = busy samples before it
  task automatic wait_a(output int n, output int nb);
    n = 0; nb = 0;
    while (!ia.valid && n < 20) begin
      if (ia.busy) nb++;
      tick();
      n++;
    end
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!ib.valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  // one request to ua with expected latency (edges after acceptance) and busy count
  task automatic run_a(input string tag, input int b, input int lat, input int nbusy);
    int n, nb;
    logic [31:0] e;
    e = ref_bcd(b, 2, 59);
    ia.start = 1'b1;
    ia.bin   = 6'(b);
    tick();
    ia.start = 1'b0;
    wait_a(n, nb);
    chk({tag, " lat"},  n, lat);
    chk({tag, " busy"}, nb, nbusy);
    chk({tag, " bcd"},  ia.bcd, e);
    chk({tag, " err"},  ia.err, (b > 59) ? 1 : 0);
    chk({tag, " busy@vld"}, ia.busy, 0);
    tick();
    chk({tag, " vld 1cyc"}, ia.valid, 0);
    chk({tag, " hold"}, ia.bcd, e);
  endtask

  initial begin
    int n, nb, hits;
    ia.start = 1'b0; ia.bin = '0;
    ib.start = 1'b0; ib.bin = '0;
    #1;
    chk("rst bcd",   ia.bcd, 0);
    chk("rst err",   ia.err, 0);
    chk("rst valid", ia.valid, 0);
    chk("rst busy",  ia.busy, 0);
    chk("rst bcd b", ib.bcd, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_a("zero", 0, 6, 6);
    run_a("v59", 59, 6, 6);
    run_a("v60", 60, 0, 0);
    run_a("v63", 63, 0, 0);
    run_a("v10", 10, 6, 6);

    // start held high: back-to-back acceptance, bin churn while busy ignored
    ia.start = 1'b1;
    ia.bin   = 6'd7;
    tick();
    chk("hold busy0", ia.busy, 1);
    ia.bin = 6'd63;
    wait_a(n, nb);
    chk("hold lat0", n, 6);
    chk("hold bcd0", ia.bcd, 32'h07);
    ia.bin = 6'd23;
    tick();
    chk("hold busy1", ia.busy, 1);
    ia.bin = 6'd1;
    wait_a(n, nb);
    chk("hold lat1", n, 6);
    chk("hold bcd1", ia.bcd, 32'h23);
    ia.bin = 6'd45;
    tick();
    ia.bin = 6'd0;
    wait_a(n, nb);
    chk("hold lat2", n, 6);
    chk("hold bcd2", ia.bcd, 32'h45);
    ia.start = 1'b0;
    tick();

    // reset during a conversion of 42
    ia.start = 1'b1;
    ia.bin   = 6'd42;
    tick();
    ia.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort bcd",   ia.bcd, 0);
    chk("abort err",   ia.err, 0);
    chk("abort valid", ia.valid, 0);
    chk("abort busy",  ia.busy, 0);
    tick();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ia.valid || ia.busy) hits++;
    end
    chk("abort no vld", hits, 0);

    // full 6-bit sweep including the out-of-range tail
    for (int v = 0; v < 64; v++) begin
      ia.start = 1'b1;
      ia.bin   = 6'(v);
      tick();
      ia.start = 1'b0;
      wait_a(n, nb);
      chk($sformatf("swA %0d", v), {ia.err, 23'd0, ia.bcd}, {(v > 59) ? 1'b1 : 1'b0, 23'd0, ref_bcd(v, 2, 59)[7:0]});
    end
    tick();

    // 10-bit / 4-digit instance
    ib.start = 1'b1;
    ib.bin   = 10'd1023;
    tick();
    ib.start = 1'b0;
    wait_b(n);
    chk("b1023 lat", n, 10);
    chk("b1023 bcd", ib.bcd, 32'h1023);
    chk("b1023 err", ib.err, 0);
    tick();
    for (int v = 0; v < 1024; v++) begin
      ib.start = 1'b1;
      ib.bin   = 10'(v);
      tick();
      ib.start = 1'b0;
      wait_b(n);
      chk($sformatf("swB %0d", v), ib.bcd, ref_bcd(v, 4, 1023));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
